rtc_uart_formatter: RTL and testbench
=====================================

// Module: rtc_uart_formatter
// PURPOSE
//  Downstream consumer of the DS1302 read stage. Snapshots the seven BCD time registers on
//  dataValid, formats them as the 23-byte ASCII line "20YY-MM-DD d HH:MM:SS\r\n", and sends it
//  one byte at a time to the UART transmitter through its start/busy handshake.
// PARAMETERS
//  DECIMATE    1   send one frame per DECIMATE accepted snapshots (1 = every snapshot)
//  TX_TIMEOUT  16  clk cycles to wait for txBusy to rise after txStart before treating the byte as sent
// PORTS
//  clk        in   1  system clock; single clock domain
//  rstN       in   1  asynchronous, active-low reset
//  secData    in   8  BCD seconds; bit7 = CH, ignored
//  minData    in   8  BCD minutes; bit7 ignored
//  hrsData    in   8  BCD hours; bit7 = 12/24 mode (1 = 12h), bit5 = PM/tens
//  dateData   in   8  BCD date
//  monData    in   8  BCD month
//  dayData    in   8  day of week; only bits[2:0] used
//  yrData     in   8  BCD year
//  dataValid  in   1  one-cycle pulse: all seven inputs valid this cycle
//  txBusy     in   1  UART transmitter busy
//  txData     out  8  byte to transmit; held stable while txStart is high and until txBusy falls
//  txStart    out  1  one-cycle pulse requesting transmission of txData
//  busy       out  1  high from capture until the last byte is done
//  frameDone  out  1  one-cycle pulse after byte 23 ('\n') completes
//  dropCnt    out  8  count of dataValid pulses ignored while busy; saturates at 255
// BEHAVIOUR
//  Reset (rstN=0, async): txData=0, txStart=0, busy=0, frameDone=0, dropCnt=0,
//   decimation counter=0, state=IDLE. Reset mid-frame aborts the frame; no further bytes are sent.
//  Capture: in IDLE, a dataValid pulse latches all seven inputs into a snapshot and increments
//   the decimation counter (mod DECIMATE). A frame starts only when the counter wraps to 0;
//   with DECIMATE=1 every snapshot starts a frame. dataValid while busy=1 does not change the
//   snapshot and increments dropCnt.
//  Frame byte order (idx 0..22): '2','0',Y1,Y0,'-',M1,M0,'-',D1,D0,' ',W,' ',h1,h0,':',m1,m0,
//   ':',s1,s0,8'h0D,8'h0A.
//  Digit mapping: a nibble 0..9 -> 8'h30+n; a nibble >9 -> '?' (8'h3F).
//   s1 = {1'b0,sec[6:4]}; m1 = {1'b0,min[6:4]}; W = {1'b0,day[2:0]}.
//   h1 = 24h mode (hrs[7]=0): hrs[5:4]; 12h mode: {3'b0,hrs[4]} (PM flag dropped). h0 = hrs[3:0].
//  FSM:
//   IDLE     -> LOAD on a frame start; busy=1, idx=0.
//   LOAD     -> txData = byte[idx]; when txBusy=0, pulse txStart for 1 cycle -> WAIT_H.
//   WAIT_H   -> WAIT_L when txBusy=1, or when TX_TIMEOUT cycles elapse after txStart.
//   WAIT_L   -> when txBusy=0: if idx==22 -> DONE, else idx+1 -> LOAD.
//   DONE     -> pulse frameDone, busy=0 -> IDLE (1 cycle).
//  Throughput: txStart is asserted no earlier than one cycle after entering LOAD. A dataValid
//   arriving in the same cycle as DONE counts as dropped. The earliest recapture is the next
//   IDLE cycle.
//  Widths: idx 5 bits; timeout counter sized $clog2(TX_TIMEOUT+1); dropCnt saturates, never wraps.
// TESTING
//  1) yr=8'h25, mon=8'h03, date=8'h14, day=8'h05, hrs=8'h09, min=8'h30, sec=8'h07, dataValid pulse,
//     model UART busy for 10 clk per byte -> bytes "2025-03-14 5 09:30:07\r\n", 23 txStart
//     pulses, one frameDone.
//  2) sec=8'h87 (CH set), hrs=8'hB1 (12h, PM, 11) -> s1='0', s0='7', h1='1', h0='1'.
//  3) min=8'h5C (bad low nibble) -> m1='5', m0='?'; the frame still completes.
//  4) 3 dataValid pulses mid-frame -> dropCnt=3, frame content unchanged; 300 pulses -> dropCnt=255.
//  5) txBusy stuck 0 -> each byte advances after TX_TIMEOUT=16 cycles; frame completes.
//  6) DECIMATE=4: 8 snapshots -> exactly 2 frames. rstN low at byte 10 -> txStart stops, all
//     outputs at reset values.

Source files
------------

// File: rtl/rtc_uart_formatter.sv
// Snapshots DS1302 BCD time registers and streams them to a UART as the
// 23-byte ASCII line "20YY-MM-DD d HH:MM:SS\r\n" over a start/busy handshake.
module rtc_uart_formatter #(
    parameter int unsigned DECIMATE   = 1,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] secData,
    input  logic [7:0] minData,
    input  logic [7:0] hrsData,
    input  logic [7:0] dateData,
    input  logic [7:0] monData,
    input  logic [7:0] dayData,
    input  logic [7:0] yrData,
    input  logic       dataValid,
    input  logic       txBusy,
    output logic [7:0] txData,
    output logic       txStart,
    output logic       busy,
    output logic       frameDone,
    output logic [7:0] dropCnt
);

    localparam int unsigned DecW    = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam int unsigned TmrW    = $clog2(TX_TIMEOUT + 1);
    localparam logic [4:0]  LastIdx = 5'd22;

    typedef enum logic [2:0] {
        Idle,
        Load,
        WaitH,
        WaitL,
        Done
    } stateT;

    stateT             state;
    logic [4:0]        idx;
    logic [TmrW-1:0]   tmr;
    logic [DecW-1:0]   decCnt;

    logic [6:0]        secSnap;
    logic [6:0]        minSnap;
    logic [6:0]        hrsSnap;   // {12h flag, hrs[5:0]}
    logic [7:0]        dateSnap;
    logic [7:0]        monSnap;
    logic [2:0]        daySnap;
    logic [7:0]        yrSnap;

    logic [4:0]        nextIdx;
    logic [7:0]        nextByte;
    logic [3:0]        hourTens;
    logic              decWrap;
    logic              tmrDone;

    // CH, the minutes top bit, the AM/PM-unrelated bit 6 and unused weekday bits carry no data.
    logic unusedBits;
    assign unusedBits = ^{secData[7], minData[7], hrsData[6], dayData[7:3]};

    function automatic logic [7:0] toAscii(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    assign decWrap  = (decCnt == DecW'(DECIMATE - 1));
    assign tmrDone  = (tmr == TmrW'(TX_TIMEOUT - 1));
    assign nextIdx  = (state == WaitL) ? (idx + 5'd1) : 5'd0;
    // In 12h mode bit 5 is the PM flag, so only bit 4 is a tens digit.
    assign hourTens = hrsSnap[6] ? {3'b000, hrsSnap[4]} : {2'b00, hrsSnap[5:4]};

    always_comb begin
        nextByte = 8'h00;
        case (nextIdx)
            5'd0:    nextByte = 8'h32;
            5'd1:    nextByte = 8'h30;
            5'd2:    nextByte = toAscii(yrSnap[7:4]);
            5'd3:    nextByte = toAscii(yrSnap[3:0]);
            5'd4:    nextByte = 8'h2D;
            5'd5:    nextByte = toAscii(monSnap[7:4]);
            5'd6:    nextByte = toAscii(monSnap[3:0]);
            5'd7:    nextByte = 8'h2D;
            5'd8:    nextByte = toAscii(dateSnap[7:4]);
            5'd9:    nextByte = toAscii(dateSnap[3:0]);
            5'd10:   nextByte = 8'h20;
            5'd11:   nextByte = toAscii({1'b0, daySnap});
            5'd12:   nextByte = 8'h20;
            5'd13:   nextByte = toAscii(hourTens);
            5'd14:   nextByte = toAscii(hrsSnap[3:0]);
            5'd15:   nextByte = 8'h3A;
            5'd16:   nextByte = toAscii({1'b0, minSnap[6:4]});
            5'd17:   nextByte = toAscii(minSnap[3:0]);
            5'd18:   nextByte = 8'h3A;
            5'd19:   nextByte = toAscii({1'b0, secSnap[6:4]});
            5'd20:   nextByte = toAscii(secSnap[3:0]);
            5'd21:   nextByte = 8'h0D;
            5'd22:   nextByte = 8'h0A;
            default: nextByte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= Idle;
            idx       <= '0;
            tmr       <= '0;
            decCnt    <= '0;
            txData    <= 8'h00;
            txStart   <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            dropCnt   <= 8'h00;
            secSnap   <= '0;
            minSnap   <= '0;
            hrsSnap   <= '0;
            dateSnap  <= '0;
            monSnap   <= '0;
            daySnap   <= '0;
            yrSnap    <= '0;
        end else begin
            txStart   <= 1'b0;
            frameDone <= 1'b0;

            // Any pulse outside Idle (including the Done cycle) is lost.
            if (dataValid && (state != Idle) && (dropCnt != 8'hFF)) begin
                dropCnt <= dropCnt + 8'd1;
            end

            case (state)
                Idle: begin
                    if (dataValid) begin
                        secSnap  <= secData[6:0];
                        minSnap  <= minData[6:0];
                        hrsSnap  <= {hrsData[7], hrsData[5:0]};
                        dateSnap <= dateData;
                        monSnap  <= monData;
                        daySnap  <= dayData[2:0];
                        yrSnap   <= yrData;
                        decCnt   <= decWrap ? '0 : decCnt + 1'b1;
                        if (decWrap) begin
                            state  <= Load;
                            busy   <= 1'b1;
                            idx    <= 5'd0;
                            txData <= nextByte;
                        end
                    end
                end
                Load: begin
                    if (!txBusy) begin
                        txStart <= 1'b1;
                        tmr     <= '0;
                        state   <= WaitH;
                    end
                end
                WaitH: begin
                    if (txBusy || tmrDone) begin
                        state <= WaitL;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                WaitL: begin
                    if (!txBusy) begin
                        if (idx == LastIdx) begin
                            state     <= Done;
                            frameDone <= 1'b1;
                        end else begin
                            idx    <= nextIdx;
                            txData <= nextByte;
                            state  <= Load;
                        end
                    end
                end
                Done: begin
                    busy  <= 1'b0;
                    state <= Idle;
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_uart_formatter.sv
// Scoreboard bench for rtc_uart_formatter: expected bytes are queued when a
// snapshot is driven and popped as each txStart is observed.
module tb_rtc_uart_formatter;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] secData, minData, hrsData, dateData, monData, dayData, yrData;
    logic       dataValid, dataValid4;
    logic       txBusy = 1'b0;
    logic       txBusy4;
    logic [7:0] txData, txData4;
    logic       txStart, txStart4;
    logic       busy, busy4;
    logic       frameDone, frameDone4;
    logic [7:0] dropCnt, dropCnt4;

    always #5 clk = ~clk;

    rtc_uart_formatter #(.DECIMATE(1), .TX_TIMEOUT(16)) dut (
        .clk(clk), .rstN(rstN),
        .secData(secData), .minData(minData), .hrsData(hrsData), .dateData(dateData),
        .monData(monData), .dayData(dayData), .yrData(yrData),
        .dataValid(dataValid), .txBusy(txBusy),
        .txData(txData), .txStart(txStart), .busy(busy),
        .frameDone(frameDone), .dropCnt(dropCnt)
    );

    assign txBusy4 = 1'b0;

    rtc_uart_formatter #(.DECIMATE(4), .TX_TIMEOUT(16)) dut4 (
        .clk(clk), .rstN(rstN),
        .secData(secData), .minData(minData), .hrsData(hrsData), .dateData(dateData),
        .monData(monData), .dayData(dayData), .yrData(yrData),
        .dataValid(dataValid4), .txBusy(txBusy4),
        .txData(txData4), .txStart(txStart4), .busy(busy4),
        .frameDone(frameDone4), .dropCnt(dropCnt4)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];
    int startCnt = 0, frameCnt = 0, frameCnt4 = 0;
    int cyc = 0, lastStart = 0;
    int busyLen = 10;
    bit stuckLow = 1'b0;
    int busyCnt = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // UART model: busy rises the cycle after txStart and stays up busyLen cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (stuckLow) begin
            txBusy  <= 1'b0;
            busyCnt <= 0;
        end else if (busyCnt == 0) begin
            if (txStart) begin
                txBusy  <= 1'b1;
                busyCnt <= busyLen;
            end
        end else begin
            busyCnt <= busyCnt - 1;
            if (busyCnt == 1) txBusy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (txStart) begin
            startCnt++;
            if (stuckLow) checkEq("timeout_gap", 32'((cyc - lastStart) >= 16), 32'd1);
            lastStart = cyc;
            if (expQ.size() == 0) checkEq("unexpected_start", 32'd1, 32'd0);
            else checkEq("tx_byte", {24'd0, txData}, {24'd0, expQ.pop_front()});
        end
        if (frameDone)  frameCnt++;
        if (frameDone4) frameCnt4++;
    end

    task automatic pushLine(input string s);
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
    endtask

    task automatic setTime(input logic [7:0] yr, mon, date, day, hrs, mn, sec);
        yrData = yr; monData = mon; dateData = date; dayData = day;
        hrsData = hrs; minData = mn; secData = sec;
    endtask

    task automatic pulse();
        @(negedge clk); dataValid = 1'b1;
        @(negedge clk); dataValid = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frameCnt < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (frameCnt < target) checkEq("frame_timeout", 32'd1, 32'd0);
        checkEq("queue_empty", 32'(expQ.size()), 32'd0);
    endtask

    task automatic waitStarts(input int target, input int budget);
        int n = 0;
        while (startCnt < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (startCnt < target) checkEq("start_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        rstN = 1'b0; dataValid = 1'b0; dataValid4 = 1'b0;
        setTime(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        checkEq("rst_txData", {24'd0, txData}, 32'd0);
        checkEq("rst_txStart", {31'd0, txStart}, 32'd0);
        checkEq("rst_busy", {31'd0, busy}, 32'd0);
        checkEq("rst_frameDone", {31'd0, frameDone}, 32'd0);
        checkEq("rst_dropCnt", {24'd0, dropCnt}, 32'd0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame
        setTime(8'h25, 8'h03, 8'h14, 8'h05, 8'h09, 8'h30, 8'h07);
        pushLine("2025-03-14 5 09:30:07");
        pulse();
        checkEq("busy_in_frame", {31'd0, busy}, 32'd1);
        waitFrames(1, 3000);
        checkEq("starts_frame1", 32'(startCnt), 32'd23);
        checkEq("frames_1", 32'(frameCnt), 32'd1);
        repeat (2) @(negedge clk);
        checkEq("busy_after", {31'd0, busy}, 32'd0);

        // CH bit ignored, 12h mode with PM flag dropped
        setTime(8'h25, 8'h03, 8'h14, 8'h05, 8'hB1, 8'h30, 8'h87);
        pushLine("2025-03-14 5 11:30:07");
        pulse();
        waitFrames(2, 3000);

        // Non-BCD nibble becomes '?'
        setTime(8'h25, 8'h03, 8'h14, 8'h05, 8'h09, 8'h5C, 8'h07);
        pushLine("2025-03-14 5 09:5?:07");
        pulse();
        waitFrames(3, 3000);

        // Pulses mid-frame are dropped and leave the snapshot alone
        setTime(8'h25, 8'h03, 8'h14, 8'h05, 8'h09, 8'h30, 8'h07);
        pushLine("2025-03-14 5 09:30:07");
        pulse();
        waitStarts(startCnt + 3, 1000);
        setTime(8'h99, 8'h12, 8'h31, 8'h07, 8'h23, 8'h59, 8'h59);
        repeat (3) pulse();
        waitFrames(4, 3000);
        checkEq("drop_3", {24'd0, dropCnt}, 32'd3);

        busyLen = 20;
        setTime(8'h25, 8'h03, 8'h14, 8'h05, 8'h09, 8'h30, 8'h07);
        pushLine("2025-03-14 5 09:30:07");
        pulse();
        waitStarts(startCnt + 1, 1000);
        repeat (300) begin
            @(negedge clk); dataValid = 1'b1;
        end
        @(negedge clk); dataValid = 1'b0;
        checkEq("drop_sat", {24'd0, dropCnt}, 32'd255);
        waitFrames(5, 4000);
        checkEq("drop_sat_hold", {24'd0, dropCnt}, 32'd255);
        busyLen = 10;

        // UART never raises busy: each byte advances on timeout
        stuckLow = 1'b1;
        repeat (3) @(negedge clk);
        pushLine("2025-03-14 5 09:30:07");
        pulse();
        waitFrames(6, 3000);
        stuckLow = 1'b0;
        repeat (3) @(negedge clk);

        // Decimation by 4: eight snapshots yield two frames
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); dataValid4 = 1'b1;
            @(negedge clk); dataValid4 = 1'b0;
            repeat (2) @(negedge clk);
            n = 0;
            while (busy4 && n < 2000) begin
                @(negedge clk); n++;
            end
            if (busy4) checkEq("dec_busy_timeout", 32'd1, 32'd0);
        end
        checkEq("dec_frames", 32'(frameCnt4), 32'd2);

        // Reset at byte 10 aborts the frame
        pushLine("2025-03-14 5 09:30:07");
        base = startCnt;
        pulse();
        waitStarts(base + 10, 1000);
        @(negedge clk);
        rstN = 1'b0;
        expQ.delete();
        #1;
        checkEq("abort_txData", {24'd0, txData}, 32'd0);
        checkEq("abort_txStart", {31'd0, txStart}, 32'd0);
        checkEq("abort_busy", {31'd0, busy}, 32'd0);
        checkEq("abort_frameDone", {31'd0, frameDone}, 32'd0);
        checkEq("abort_dropCnt", {24'd0, dropCnt}, 32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (300) @(negedge clk);
        checkEq("abort_no_starts", 32'(startCnt), 32'(base + 10));
        checkEq("abort_no_frame", 32'(frameCnt), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
